// File: rtl/sub_pipe_64bit.sv
// sub_pipe_64bit
// Two-stage pipelined 64-bit subtractor producing ARMv8 NZCV flags.
// D = A + ~B + Cin (Cin = 1 means no borrow). The low 32-bit half is summed
// in stage 1 and the high half plus the stage-1 carry in stage 2. Both stages
// use a valid/ready handshake, so each stage can hold one operation under
// backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand set on A/B/Cin is presented
//   in_ready   operand set is accepted this cycle
//   A, B, Cin  minuend, subtrahend, carry-in
//   out_valid  D and flags are valid
//   out_ready  downstream consumes the result this cycle
//   D          difference
//   N, Z, C, V condition flags for D
module sub_pipe_64bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] D,
  output logic        N,
  output logic        Z,
  output logic        C,
  output logic        V
);

  // Pipeline advance enables
  logic adv1;
  logic adv2;

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic [31:0] lo_sum_q,   lo_sum_d;
  logic        lo_zero_q,  lo_zero_d;
  logic        c31_q,      c31_d;
  logic [31:0] a_hi_q,     a_hi_d;
  logic [31:0] nb_hi_q,    nb_hi_d;

  // Stage 2 state
  logic        out_valid_q, out_valid_d;
  logic [63:0] d_q,         d_d;
  logic        n_q,         n_d;
  logic        z_q,         z_d;
  logic        c_q,         c_d;
  logic        v_q,         v_d;

  // Combinational sums
  logic [32:0] lo_full;
  logic [32:0] hi_full;
  logic        b63;

  // Stage 2 drains when empty or consumed; stage 1 when empty or stage 2 drains.
  always_comb begin
    adv2     = ~out_valid_q | out_ready;
    adv1     = ~s1_valid_q | adv2;
    in_ready = adv1;
  end

  // Low half: the carry out of bit 31 is what crosses the stage boundary.
  always_comb begin
    lo_full = {1'b0, A[31:0]} + {1'b0, ~B[31:0]} + {32'd0, Cin};
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    lo_sum_d   = lo_sum_q;
    lo_zero_d  = lo_zero_q;
    c31_d      = c31_q;
    a_hi_d     = a_hi_q;
    nb_hi_d    = nb_hi_q;
    if (adv1) begin
      // Loading from an empty input yields a bubble; data is left untouched.
      s1_valid_d = in_valid;
      if (in_valid) begin
        lo_sum_d  = lo_full[31:0];
        lo_zero_d = (lo_full[31:0] == '0);
        c31_d     = lo_full[32];
        a_hi_d    = A[63:32];
        nb_hi_d   = ~B[63:32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      lo_sum_q   <= '0;
      lo_zero_q  <= 1'b0;
      c31_q      <= 1'b0;
      a_hi_q     <= '0;
      nb_hi_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      lo_sum_q   <= lo_sum_d;
      lo_zero_q  <= lo_zero_d;
      c31_q      <= c31_d;
      a_hi_q     <= a_hi_d;
      nb_hi_q    <= nb_hi_d;
    end
  end

  // High half: carry out of bit 63 is the ARM C flag (1 = no borrow).
  always_comb begin
    hi_full = {1'b0, a_hi_q} + {1'b0, nb_hi_q} + {32'd0, c31_q};
    b63     = ~nb_hi_q[31];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    d_d         = d_q;
    n_d         = n_q;
    z_d         = z_q;
    c_d         = c_q;
    v_d         = v_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      // Result registers only change when a real operation arrives, so a
      // stalled result stays put and bubbles never disturb D.
      if (s1_valid_q) begin
        d_d = {hi_full[31:0], lo_sum_q};
        n_d = hi_full[31];
        z_d = lo_zero_q & (hi_full[31:0] == '0);
        c_d = hi_full[32];
        v_d = (a_hi_q[31] != b63) & (hi_full[31] != a_hi_q[31]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      v_q         <= v_d;
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    D         = d_q;
    N         = n_q;
    Z         = z_q;
    C         = c_q;
    V         = v_q;
  end

endmodule

// File: tb/tb_sub_pipe_64bit.sv
// Directed and randomized checks for sub_pipe_64bit.
module tb_sub_pipe_64bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] A;
  logic [63:0] B;
  logic        Cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] D;
  logic        N, Z, C, V;

  int unsigned checks = 0;
  int unsigned errors = 0;

  sub_pipe_64bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .N         (N),
    .Z         (Z),
    .C         (C),
    .V         (V)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference: plain subtraction, unsigned compare for C, wide signed math for V.
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b, input logic cin);
    logic [63:0] d;
    logic [65:0] full;
    logic [65:0] sx;
    logic        c;
    logic        v;
    d    = a - b - {63'd0, ~cin};
    c    = ({1'b0, a} >= ({1'b0, b} + {64'd0, ~cin}));
    full = {{2{a[63]}}, a} - {{2{b[63]}}, b} - {65'd0, ~cin};
    sx   = {{2{d[63]}}, d};
    v    = (full != sx);
    return {d, d[63], (d == 64'd0), c, v};
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h0000_0000_FFFF_FFFF;
      4:       return 64'h0000_0001_0000_0000;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Cin = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, D, N, Z, C, V} !== 69'd0) begin
      errors++;
      $display("FAIL reset_outputs: got out_valid=%b D=%h NZCV=%b%b%b%b, want all zero", out_valid, D, N, Z, C, V);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    // Inputs presented during reset must not leak through.
    in_valid = 1'b1; A = 64'd10; B = 64'd4; Cin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    rst = 1'b0;
    // First edge after release accepts the operand.
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_lat1: got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({out_valid, D, N, Z, C, V} !== {1'b1, 64'd6, 4'b0010}) begin
      errors++;
      $display("FAIL reset_first_op: got v=%b D=%h NZCV=%b%b%b%b want v=1 D=6 NZCV=0010", out_valid, D, N, Z, C, V);
    end
  endtask

  task automatic test_directed();
    logic [63:0] ta [8];
    logic [63:0] tb [8];
    logic        tc [8];
    logic [63:0] td [8];
    logic [3:0]  tf [8];
    ta[0] = 64'd5;                  tb[0] = 64'd3;                  tc[0] = 1'b1; td[0] = 64'd2;                  tf[0] = 4'b0010;
    ta[1] = 64'd3;                  tb[1] = 64'd5;                  tc[1] = 1'b1; td[1] = 64'hFFFF_FFFF_FFFF_FFFE; tf[1] = 4'b1000;
    ta[2] = 64'd7;                  tb[2] = 64'd7;                  tc[2] = 1'b1; td[2] = 64'd0;                  tf[2] = 4'b0110;
    ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'd1;                  tc[3] = 1'b1; td[3] = 64'h7FFF_FFFF_FFFF_FFFF; tf[3] = 4'b0011;
    ta[4] = 64'h0000_0001_0000_0000; tb[4] = 64'd0;                  tc[4] = 1'b0; td[4] = 64'h0000_0000_FFFF_FFFF; tf[4] = 4'b0010;
    ta[5] = 64'd0;                  tb[5] = 64'd0;                  tc[5] = 1'b1; td[5] = 64'd0;                  tf[5] = 4'b0110;
    ta[6] = 64'd0;                  tb[6] = 64'd0;                  tc[6] = 1'b0; td[6] = 64'hFFFF_FFFF_FFFF_FFFF; tf[6] = 4'b1000;
    ta[7] = 64'h7FFF_FFFF_FFFF_FFFF; tb[7] = 64'hFFFF_FFFF_FFFF_FFFF; tc[7] = 1'b1; td[7] = 64'h8000_0000_0000_0000; tf[7] = 4'b1001;
    drain();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; A = ta[i]; B = tb[i]; Cin = tc[i]; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL directed%0d_in_ready: got %b want 1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d_early: got out_valid=%b want 0", i, out_valid);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if ({out_valid, D, N, Z, C, V} !== {1'b1, td[i], tf[i]}) begin
        errors++;
        $display("FAIL directed%0d_result: got v=%b D=%h NZCV=%b%b%b%b want v=1 D=%h NZCV=%b",
                 i, out_valid, D, N, Z, C, V, td[i], tf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned sent = 0;
    int unsigned got  = 0;
    int          first_cyc = -1;
    logic [63:0] exp_d;
    drain();
    @(posedge clk); #1;
    in_valid = 1'b1; A = 64'd7; B = 64'd0; Cin = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (in_valid) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready cyc%0d: got %b want 1", cyc, in_ready);
        end
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        exp_d = 64'(100 * got + 7 - got * got);
        checks++;
        if ({D, N, Z, C, V} !== {exp_d, 4'b0010} || cyc != first_cyc + int'(got)) begin
          errors++;
          $display("FAIL b2b_result%0d: got D=%h NZCV=%b%b%b%b at cyc %0d want D=%h NZCV=0010 at cyc %0d",
                   got, D, N, Z, C, V, cyc, exp_d, first_cyc + int'(got));
        end
        got++;
      end
      @(posedge clk); #1;
      if (in_valid) sent++;
      in_valid = (sent < 6);
      A = 64'(100 * sent + 7);
      B = 64'(sent * sent);
    end
    checks++;
    if (got != 6 || first_cyc != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d results first at cyc %0d, want 6 first at cyc 2", got, first_cyc);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic [63:0] vd [4];
    logic [3:0]  vf [4];
    int unsigned idx = 0;
    int unsigned got = 0;
    int          first_cyc = -1;
    int          last_cyc  = -1;
    logic        hs_in;
    va[0] = 64'd10;                  vb[0] = 64'd1; vd[0] = 64'd9;                  vf[0] = 4'b0010;
    va[1] = 64'd0;                   vb[1] = 64'd1; vd[1] = 64'hFFFF_FFFF_FFFF_FFFF; vf[1] = 4'b1000;
    va[2] = 64'h0000_0001_0000_0000; vb[2] = 64'd1; vd[2] = 64'h0000_0000_FFFF_FFFF; vf[2] = 4'b0010;
    va[3] = 64'd0;                   vb[3] = 64'd0; vd[3] = 64'd0;                  vf[3] = 4'b0110;
    drain();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; A = va[0]; B = vb[0]; Cin = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (cyc >= 2 && cyc <= 5) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || {D, N, Z, C, V} !== {vd[0], vf[0]}) begin
          errors++;
          $display("FAIL bp_stall cyc%0d: got in_ready=%b out_valid=%b D=%h NZCV=%b%b%b%b want 0/1 D=%h NZCV=%b",
                   cyc, in_ready, out_valid, D, N, Z, C, V, vd[0], vf[0]);
        end
      end
      if (cyc == 5) begin
        checks++;
        if (idx != 2) begin
          errors++;
          $display("FAIL bp_accepts: got %0d accepted while stalled, want 2", idx);
        end
      end
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        checks++;
        if (got >= 4 || {D, N, Z, C, V} !== {vd[got], vf[got]}) begin
          errors++;
          $display("FAIL bp_result%0d: got D=%h NZCV=%b%b%b%b want D=%h NZCV=%b",
                   got, D, N, Z, C, V, vd[got % 4], vf[got % 4]);
        end
        got++;
      end
      hs_in = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs_in) idx++;
      in_valid  = (idx < 4);
      A         = va[idx % 4];
      B         = vb[idx % 4];
      out_ready = (cyc >= 5);
    end
    checks++;
    if (got != 4 || last_cyc - first_cyc != 3) begin
      errors++;
      $display("FAIL bp_drain: got %0d results over cycles %0d..%0d, want 4 in consecutive cycles", got, first_cyc, last_cyc);
    end
  endtask

  task automatic test_random();
    logic [67:0] exp_q [$];
    logic [67:0] exp;
    logic [67:0] held;
    logic        hold_chk = 1'b0;
    logic        hs_in;
    int unsigned sent = 0;
    int unsigned got  = 0;
    int unsigned bad  = 0;
    drain();
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 5000 && got < 400; cyc++) begin
      @(negedge clk);
      if (hold_chk) begin
        checks++;
        if (out_valid !== 1'b1 || {D, N, Z, C, V} !== held) begin
          errors++;
          $display("FAIL rand_hold cyc%0d: got v=%b D=%h NZCV=%b%b%b%b want v=1 %h", cyc, out_valid, D, N, Z, C, V, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious cyc%0d: got output D=%h with nothing outstanding", cyc, D);
        end else begin
          exp = exp_q.pop_front();
          if ({D, N, Z, C, V} !== exp) begin
            errors++;
            bad++;
            if (bad < 10)
              $display("FAIL rand_result%0d: got D=%h NZCV=%b%b%b%b want D=%h NZCV=%b",
                       got, D, N, Z, C, V, exp[67:4], exp[3:0]);
          end
        end
        got++;
      end
      hold_chk = out_valid && !out_ready;
      held     = {D, N, Z, C, V};
      hs_in    = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs_in) begin
        exp_q.push_back(model(A, B, Cin));
        sent++;
      end
      in_valid  = (sent < 400) && ($urandom_range(0, 9) < 7);
      A         = rand_op();
      B         = rand_op();
      Cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
    end
    checks++;
    if (got != 400 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rand_complete: got %0d results, %0d outstanding, want 400 and 0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int unsigned stale = 0;
    drain();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; A = 64'd20; B = 64'd5; Cin = 1'b1;
    @(posedge clk); #1;
    A = 64'd30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || D !== 64'd15 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_setup: got out_valid=%b D=%h in_ready=%b want 1/f/0", out_valid, D, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, D, N, Z, C, V} !== 69'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_clear: got v=%b D=%h NZCV=%b%b%b%b in_ready=%b want zeros and in_ready=1",
               out_valid, D, N, Z, C, V, in_ready);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL midrst_stale: got %0d cycles with out_valid after reset, want 0", stale);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; A = 64'd9; B = 64'd9; Cin = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_early: got out_valid=%b want 0", out_valid);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({out_valid, D, N, Z, C, V} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000}) begin
      errors++;
      $display("FAIL midrst_next: got v=%b D=%h NZCV=%b%b%b%b want v=1 D=ffffffffffffffff NZCV=1000",
               out_valid, D, N, Z, C, V);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
